// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: active-low hex glyph patterns and the
// scan-capture FSM state type.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Index n holds the glyph for nibble n.
  localparam logic [15:0][6:0] SEG_HEX = {
    SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
    SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
  };

  typedef enum logic {
    SEEK = 1'b0,
    HOLD = 1'b1
  } scan_state_e;

endpackage

// File: rtl/seg_pattern_encoder.sv
// Combinational inverse of the hex-to-segment decoder: maps an active-low
// glyph back to its nibble and flags blank or unrecognised patterns.
module seg_pattern_encoder
  import seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       blank,
  output logic       unrec
);

  always_comb begin
    nibble = 4'h0;
    blank  = 1'b0;
    unrec  = 1'b1;
    if (pattern == SEG_BLANK) begin
      blank = 1'b1;
      unrec = 1'b0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (pattern == SEG_HEX[i]) begin
          nibble = 4'(i);
          unrec  = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/seg_scan_capture.sv
// Multiplexed seven-segment bus monitor: captures one nibble per digit once
// its dwell is stable and publishes a full frame when all digits are seen.
//
// state | meaning
// SEEK  | waiting for a stable dwell with a valid digit select
// HOLD  | digit committed; waiting for the bus to change
module seg_scan_capture
  import seg_pkg::*;
#(
  parameter int DIGITS        = 6,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIGITS-1:0]     seg_sel,
  input  logic [6:0]            seg_data,
  output logic [4*DIGITS-1:0]   frame_data,
  output logic [DIGITS-1:0]     frame_blank,
  output logic                  frame_err,
  output logic                  frame_valid,
  output logic                  digit_commit
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

  logic [DIGITS-1:0] samp_sel;
  logic [6:0]        samp_data;
  logic [CNT_W-1:0]  cnt;
  logic              in_diff;
  logic              cnt_full;

  logic [DIGITS-1:0] sel_low;
  logic              sel_valid;
  logic [IDX_W-1:0]  sel_idx;

  logic [3:0]        enc_nibble;
  logic              enc_blank;
  logic              enc_unrec;

  scan_state_e       state_q;
  scan_state_e       state_d;
  logic              commit;

  logic [DIGITS-1:0][3:0] slots;
  logic [DIGITS-1:0][3:0] slots_d;
  logic [DIGITS-1:0]      seen;
  logic [DIGITS-1:0]      seen_d;
  logic [DIGITS-1:0]      blank_acc;
  logic [DIGITS-1:0]      blank_acc_d;
  logic                   err_acc;
  logic                   err_acc_d;
  logic                   frame_done;

  assign in_diff  = (seg_sel != samp_sel) || (seg_data != samp_data);
  assign cnt_full = (cnt == CNT_W'(STABLE_CYCLES));

  always_ff @(posedge clk) begin
    if (rst) begin
      samp_sel  <= '0;
      samp_data <= '0;
      cnt       <= '0;
    end else if (in_diff) begin
      samp_sel  <= seg_sel;
      samp_data <= seg_data;
      cnt       <= CNT_W'(1);
    end else if (!cnt_full) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Valid select has exactly one low bit: a non-zero power of two once inverted.
  assign sel_low   = ~samp_sel;
  assign sel_valid = (sel_low != '0) && ((sel_low & (sel_low - DIGITS'(1))) == '0);

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!samp_sel[i]) sel_idx = IDX_W'(i);
    end
  end

  seg_pattern_encoder u_enc (
    .pattern (samp_data),
    .nibble  (enc_nibble),
    .blank   (enc_blank),
    .unrec   (enc_unrec)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= SEEK;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SEEK: if (cnt_full && sel_valid) state_d = HOLD;
      HOLD: if (in_diff)               state_d = SEEK;
      default:                         state_d = SEEK;
    endcase
  end

  always_comb begin
    commit = (state_q == SEEK) && cnt_full && sel_valid;
  end

  assign frame_done = &seen;

  // A commit landing on the frame-completion edge starts the next frame.
  always_comb begin
    slots_d     = slots;
    seen_d      = frame_done ? '0   : seen;
    blank_acc_d = frame_done ? '0   : blank_acc;
    err_acc_d   = frame_done ? 1'b0 : err_acc;
    if (commit) begin
      slots_d[sel_idx]     = enc_nibble;
      seen_d[sel_idx]      = 1'b1;
      blank_acc_d[sel_idx] = enc_blank;
      err_acc_d            = err_acc_d | enc_unrec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slots        <= '0;
      seen         <= '0;
      blank_acc    <= '0;
      err_acc      <= 1'b0;
      digit_commit <= 1'b0;
      frame_valid  <= 1'b0;
      frame_data   <= '0;
      frame_blank  <= '0;
      frame_err    <= 1'b0;
    end else begin
      slots        <= slots_d;
      seen         <= seen_d;
      blank_acc    <= blank_acc_d;
      err_acc      <= err_acc_d;
      digit_commit <= commit;
      frame_valid  <= frame_done;
      if (frame_done) begin
        frame_data  <= slots;
        frame_blank <= blank_acc;
        frame_err   <= err_acc;
      end
    end
  end

endmodule

// File: doc/seg_scan_capture.md
Name: seg_scan_capture

Overview:
Reads back a multiplexed seven-segment display bus (active-low segment pattern plus active-low digit select), the reverse direction of the team's hex-to-segment decoding. For each digit it waits until the dwell is stable, then converts the pattern back to a hex nibble and stores it per digit. Once every digit has been captured, it emits one complete frame.
Used as an on-chip display monitor and as a self-check tap on the LED/seg scan path.

Parameters:
DIGITS, 6, number of multiplexed digit positions.
STABLE_CYCLES, 4, consecutive identical samples required before a digit is committed (minimum 2).

Ports:
clk  input  1  system clock
rst  input  1  reset: synchronous, active-high
seg_sel  input  DIGITS  digit select, active-low, exactly one bit 0 when valid
seg_data  input  7  segment pattern, active-low, bit0=a … bit6=g
frame_data  output  4*DIGITS  nibble per digit, digit 0 in bits [3:0]
frame_blank  output  DIGITS  1 = digit showed blank pattern 7'h7F
frame_err  output  1  1 = at least one digit in frame had an unrecognised pattern
frame_valid  output  1  one-cycle pulse when frame_* updated
digit_commit  output  1  one-cycle pulse per committed digit (debug)

Behaviour:
- Reset values: all outputs 0; internal slots, seen mask, error and blank accumulators 0; FSM in SEEK; stability count 0. Reset mid-frame discards all partial captures.
- Input stage: {seg_sel, seg_data} registered every clk into a sample register (S).
- Stability count (cnt):
  - On an edge where the input differs from S: S loads and cnt := 1.
  - On an edge where the input equals S: cnt increments, saturating at STABLE_CYCLES.
- Select validity: S.sel is valid only if exactly one bit is 0. If invalid, no commit occurs, but counting still runs.
- FSM:
  - SEEK: when cnt == STABLE_CYCLES and S.sel is valid, commit on the next edge and go to HOLD.
  - HOLD: stay until the input differs from S, then go to SEEK.
  - Result: exactly one commit per stable dwell, however long the dwell lasts.
- Commit:
  - Slot[idx of 0 bit] := encoded nibble; seen[idx] := 1; digit_commit pulses.
  - err_acc |= unrecognised; blank_acc[idx] := blank.
  - Re-committing an already-seen slot before the frame completes overwrites that slot. err_acc stays sticky.
- Encoding (7-bit hex, active-low): 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 10→9, 08→A, 03→b, 46→C, 21→d, 06→E, 0E→F.
  - 7F → nibble 0, blank=1.
  - Any other pattern → nibble 0, unrecognised=1.
- Frame completion: on the edge after a commit that makes seen all-ones:
  - frame_data, frame_blank and frame_err are loaded, and frame_valid = 1 for one cycle.
  - seen, err_acc and blank_acc are cleared in the same edge.
  - A commit arriving in that same edge counts toward the next frame.
- frame_* outputs hold between pulses.
- Latency: with the input steady from just before edge E1, the commit occurs at edge E(STABLE_CYCLES+1) and frame_valid at edge E(STABLE_CYCLES+2).

Decomposition:
- Package seg_pkg holds:
  - The 16 segment-pattern constants and SEG_BLANK = 7'h7F, shared with the forward decoder.
  - The FSM state enum {SEEK, HOLD}.
- Sub-module seg_pattern_encoder (combinational): 7-bit pattern → {nibble[3:0], blank, unrecognised}.

Test Plan:
- Scan digits 0..5 showing 0,1,2,3,4,5, dwell 8 cycles each, STABLE_CYCLES=4 → one frame_valid; frame_data=24'h543210, frame_blank=0, frame_err=0; six digit_commit pulses.
- Digit 3 dwell shortened to 3 cycles (glitch) → no commit for slot 3 and no frame_valid. A later 8-cycle dwell showing 'A' on digit 3 → frame with nibble 3 = A.
- Digit 2 pattern 7'h7E (invalid) in an otherwise good scan → frame_err=1, bits [11:8]=0; the next clean frame has frame_err=0.
- Digit 5 pattern 7'h7F → frame_blank=6'b100000, bits [23:20]=0, frame_err=0.
- seg_sel=6'b111111, then 6'b111100, each held 10 cycles → no digit_commit, no state change in slots.
- Commit digits 0..2, assert rst for 1 cycle, then commit digits 3..5 → no frame_valid. After re-committing 0..2 → frame_valid once, with 0..2 values taken from after the reset.
